// File: rtl/collision_detector.sv
// collision_detector: per-frame bird/wall/floor collision check and score keeper.
// A frame tick starts a short compare sequence (sample, x-overlap, y-gap, update).
// A hit latches the sticky collision level until restart.
// Optional build macro: CEILING_HIT_EN (a sampled bird_y of zero also counts as a hit).
module collision_detector #(
    parameter int unsigned BIRD_X   = 20,
    parameter int unsigned BIRD_W   = 4,
    parameter int unsigned BIRD_H   = 4,
    parameter int unsigned WALL_W   = 8,
    parameter int unsigned GAP_H    = 30,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flag,
    input  logic               i_restart,
    input  logic [6:0]         i_bird_y,
    input  logic [7:0]         i_wall_x,
    input  logic [6:0]         i_gap_y,
    output logic               o_collision,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StCheckX,
        StCheckY,
        StUpdate,
        StHit
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [6:0]         r_bird_y;
    logic [7:0]         r_wall_x;
    logic [6:0]         r_gap_y;
    logic [7:0]         r_prev_x;
    logic               r_ovx;
    logic               r_outgap;
    logic               r_floor;
    logic               r_scored;
    logic               r_collision;
    logic [SCORE_W-1:0] r_score;
    logic               r_overrun;

    logic [8:0] w_wall_end;
    logic [7:0] w_bird_bot;
    logic [7:0] w_gap_bot;
    logic       w_ceiling;
    logic       w_hit;
    logic       w_passed;

    // Widened sums so the compares never wrap.
    assign w_wall_end = {1'b0, r_wall_x} + 9'(WALL_W);
    assign w_bird_bot = {1'b0, r_bird_y} + 8'(BIRD_H);
    assign w_gap_bot  = {1'b0, r_gap_y} + 8'(GAP_H);
    assign w_passed   = (w_wall_end <= 9'(BIRD_X));

`ifdef CEILING_HIT_EN
    assign w_ceiling = (r_bird_y == 7'd0);
`else
    assign w_ceiling = 1'b0;
`endif

    assign w_hit = (r_ovx && r_outgap) || r_floor || w_ceiling;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the busy/done strobes.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_flag) w_state_next = StSample;
            end
            StSample: begin
                o_busy       = 1'b1;
                w_state_next = StCheckX;
            end
            StCheckX: begin
                o_busy       = 1'b1;
                w_state_next = StCheckY;
            end
            StCheckY: begin
                o_busy       = 1'b1;
                w_state_next = StUpdate;
            end
            StUpdate: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = w_hit ? StHit : StIdle;
            end
            StHit: begin
                // restart outranks a coincident flag, which is simply dropped
                if (i_restart) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: capture, compare stages, score/collision update and overrun flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bird_y    <= '0;
            r_wall_x    <= '0;
            r_gap_y     <= '0;
            r_prev_x    <= '0;
            r_ovx       <= 1'b0;
            r_outgap    <= 1'b0;
            r_floor     <= 1'b0;
            r_scored    <= 1'b0;
            r_collision <= 1'b0;
            r_score     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (o_busy && i_flag) r_overrun <= 1'b1;
            unique case (r_state)
                StSample: begin
                    r_bird_y <= i_bird_y;
                    r_wall_x <= i_wall_x;
                    r_gap_y  <= i_gap_y;
                end
                StCheckX: begin
                    r_ovx <= ({1'b0, r_wall_x} < 9'(BIRD_X + BIRD_W)) &&
                             (w_wall_end > 9'(BIRD_X));
                    // wall_x moving right means a fresh wall entered from the right edge
                    if (r_wall_x > r_prev_x) r_scored <= 1'b0;
                end
                StCheckY: begin
                    r_outgap <= (r_bird_y < r_gap_y) || (w_bird_bot > w_gap_bot);
                    r_floor  <= (w_bird_bot > 8'(SCREEN_H));
                end
                StUpdate: begin
                    r_prev_x <= r_wall_x;
                    if (w_hit) begin
                        r_collision <= 1'b1;
                    end else if (w_passed && !r_scored) begin
                        if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
                        r_scored <= 1'b1;
                    end
                end
                StHit: begin
                    if (i_restart) begin
                        r_collision <= 1'b0;
                        r_score     <= '0;
                        r_scored    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_collision = r_collision;
    assign o_score     = r_score;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed scenarios then randomized frames,
// all outputs compared every cycle against a frame-level behavioural model.
module tb_collision_detector;

    localparam int BX = 20, BW = 4, BH = 4, WW = 8, GH = 30, SH = 120, SW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_flag;
    logic          i_restart;
    logic [6:0]    i_bird_y;
    logic [7:0]    i_wall_x;
    logic [6:0]    i_gap_y;
    logic          o_collision;
    logic [SW-1:0] o_score;
    logic          o_done;
    logic          o_busy;
    logic          o_overrun;

    collision_detector dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flag      (i_flag),
        .i_restart   (i_restart),
        .i_bird_y    (i_bird_y),
        .i_wall_x    (i_wall_x),
        .i_gap_y     (i_gap_y),
        .o_collision (o_collision),
        .o_score     (o_score),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Model: frame evaluation as a countdown of remaining busy cycles.
    int m_cnt;
    bit m_hit_state;
    bit m_coll;
    bit m_over;
    bit m_scored;
    int m_score;
    int m_prev;
    int s_bird, s_wall, s_gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit frame_hit(input int b, input int w, input int g);
        bit ovx, outgap, flr, ceil;
        ovx    = (w < BX + BW) && (w + WW > BX);
        outgap = (b < g) || (b + BH > g + GH);
        flr    = (b + BH > SH);
`ifdef CEILING_HIT_EN
        ceil   = (b == 0);
`else
        ceil   = 1'b0;
`endif
        return (ovx && outgap) || flr || ceil;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_hit_state = 0; m_coll = 0; m_over = 0;
        m_scored = 0; m_score = 0; m_prev = 0;
        s_bird = 0; s_wall = 0; s_gap = 0;
    endtask

    // Advance the model over one clock edge using the inputs currently applied.
    task automatic model_edge();
        if (m_hit_state) begin
            if (i_restart) begin
                m_hit_state = 0; m_coll = 0; m_score = 0; m_scored = 0;
            end
        end else if (m_cnt > 0) begin
            if (i_flag) m_over = 1;
            if (m_cnt == 4) begin
                s_bird = int'(i_bird_y); s_wall = int'(i_wall_x); s_gap = int'(i_gap_y);
            end
            if (m_cnt == 1) begin
                if (s_wall > m_prev) m_scored = 0;
                if (frame_hit(s_bird, s_wall, s_gap)) begin
                    m_coll = 1; m_hit_state = 1;
                end else if (s_wall + WW <= BX && !m_scored) begin
                    if (m_score < (1 << SW) - 1) m_score++;
                    m_scored = 1;
                end
                m_prev = s_wall;
            end
            m_cnt--;
        end else if (i_flag) begin
            m_cnt = 4;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"},      32'(o_busy),      32'(m_cnt > 0));
        check({tag, ".done"},      32'(o_done),      32'(m_cnt == 1));
        check({tag, ".collision"}, 32'(o_collision), 32'(m_coll));
        check({tag, ".score"},     32'(o_score),     32'(m_score));
        check({tag, ".overrun"},   32'(o_overrun),   32'(m_over));
    endtask

    task automatic step(input string tag);
        if (i_reset) m_reset();
        else model_edge();
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    task automatic frame(input string tag);
        i_flag = 1'b1;
        step(tag);
        i_flag = 1'b0;
        repeat (5) step(tag);
    endtask

    initial begin
        i_reset = 1'b1; i_flag = 1'b0; i_restart = 1'b0;
        i_bird_y = '0; i_wall_x = '0; i_gap_y = '0;
        m_reset();
        #1;
        check_all("reset");
        step("reset");
        i_reset = 1'b0;
        step("idle");

        // 1: plain frame, no hit, no score; done exactly 4 cycles after the tick
        i_bird_y = 7'd50; i_gap_y = 7'd40; i_wall_x = 8'd200;
        frame("t1");
        check("t1.collision_const", 32'(o_collision), 32'd0);

        // 2: overlapping wall with bird above the gap
        i_bird_y = 7'd10; i_gap_y = 7'd40; i_wall_x = 8'd18;
        frame("t2");
        check("t2.collision_const", 32'(o_collision), 32'd1);
        frame("t2_ignored");
        i_restart = 1'b1; step("t2_restart"); i_restart = 1'b0;
        step("t2_idle");

        // 3: passed wall scores once across two frames
        i_bird_y = 7'd50; i_gap_y = 7'd40; i_wall_x = 8'd8;
        frame("t3a");
        frame("t3b");
        check("t3.score_const", 32'(o_score), 32'd1);

        // 4: floor hit, then restart clears collision and score
        i_bird_y = 7'd118; i_wall_x = 8'd200;
        frame("t4");
        check("t4.collision_const", 32'(o_collision), 32'd1);
        i_restart = 1'b1; i_flag = 1'b1; step("t4_restart");
        i_restart = 1'b0; i_flag = 1'b0;
        step("t4_idle");
        check("t4.score_const", 32'(o_score), 32'd0);
        check("t4.no_overrun", 32'(o_overrun), 32'd0);

        // 5: second tick while busy is dropped and flags overrun
        i_bird_y = 7'd50; i_gap_y = 7'd40; i_wall_x = 8'd150;
        i_flag = 1'b1; step("t5");
        i_flag = 1'b0; step("t5");
        i_flag = 1'b1; step("t5");
        i_flag = 1'b0;
        repeat (5) step("t5");
        check("t5.overrun_const", 32'(o_overrun), 32'd1);

        // 6: bird at the very top, wall far away
        i_bird_y = 7'd0; i_gap_y = 7'd40; i_wall_x = 8'd200;
        frame("t6");
`ifdef CEILING_HIT_EN
        check("t6.collision_const", 32'(o_collision), 32'd1);
`else
        check("t6.collision_const", 32'(o_collision), 32'd0);
`endif

        // reset in the middle of an evaluation
        i_reset = 1'b1; step("rst_hit"); i_reset = 1'b0;
        i_bird_y = 7'd50; i_gap_y = 7'd40; i_wall_x = 8'd100;
        i_flag = 1'b1; step("mid_rst"); i_flag = 1'b0;
        step("mid_rst");
        i_reset = 1'b1;
        #1;
        m_reset();
        check_all("mid_rst_async");
        step("mid_rst");
        i_reset = 1'b0;
        step("mid_rst_idle");

        // randomized frames with inputs changing every cycle
        for (int i = 0; i < 3000; i++) begin
            int g;
            i_flag    = ($urandom_range(0, 5) == 0);
            i_restart = ($urandom_range(0, 9) == 0);
            g         = $urandom_range(0, 90);
            i_gap_y   = 7'(g);
            i_bird_y  = ($urandom_range(0, 1) == 0) ? 7'(g + $urandom_range(0, 26))
                                                     : 7'($urandom_range(0, 127));
            i_wall_x  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30))
                                                     : 8'($urandom_range(0, 255));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
